// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: opcodes, funct3 codes, ALU/write-back selectors and
// the decode helpers used by the single-cycle core.
package rv32_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned RIDX = 5;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h8000_0000;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU, WB_PC4, WB_MEM
  } wb_sel_e;

  function automatic logic is_load_f3(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic is_store_f3(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

  // SUB only exists in the register-register form; OP-IMM bit 30 is immediate data.
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt,
                                          input logic reg_form);
    case (f3)
      3'b000:  return (alt && reg_form) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv32_regfile.sv
// 32x32 integer register file: x0 hard-wired to zero, two async read ports,
// one write port landing at the clock edge, every register visible as gpr_N.
module rv32_regfile
  import rv32_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic [RIDX-1:0] rs1_addr,
  input  logic [RIDX-1:0] rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wen,
  input  logic [RIDX-1:0] rd_addr,
  input  logic [XLEN-1:0] rd_data
);

  logic [XLEN-1:0] regs [NREG];
  logic [XLEN-1:0] view [NREG];

  logic [XLEN-1:0] gpr_0,  gpr_1,  gpr_2,  gpr_3,  gpr_4,  gpr_5,  gpr_6,  gpr_7;
  logic [XLEN-1:0] gpr_8,  gpr_9,  gpr_10, gpr_11, gpr_12, gpr_13, gpr_14, gpr_15;
  logic [XLEN-1:0] gpr_16, gpr_17, gpr_18, gpr_19, gpr_20, gpr_21, gpr_22, gpr_23;
  logic [XLEN-1:0] gpr_24, gpr_25, gpr_26, gpr_27, gpr_28, gpr_29, gpr_30, gpr_31;

  // Entry 0 is cleared on reset and never written, so it always reads zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
    end else if (wen && (rd_addr != '0)) begin
      regs[rd_addr] <= rd_data;
    end
  end

  assign gpr_0  = regs[0];  assign gpr_1  = regs[1];  assign gpr_2  = regs[2];
  assign gpr_3  = regs[3];  assign gpr_4  = regs[4];  assign gpr_5  = regs[5];
  assign gpr_6  = regs[6];  assign gpr_7  = regs[7];  assign gpr_8  = regs[8];
  assign gpr_9  = regs[9];  assign gpr_10 = regs[10]; assign gpr_11 = regs[11];
  assign gpr_12 = regs[12]; assign gpr_13 = regs[13]; assign gpr_14 = regs[14];
  assign gpr_15 = regs[15]; assign gpr_16 = regs[16]; assign gpr_17 = regs[17];
  assign gpr_18 = regs[18]; assign gpr_19 = regs[19]; assign gpr_20 = regs[20];
  assign gpr_21 = regs[21]; assign gpr_22 = regs[22]; assign gpr_23 = regs[23];
  assign gpr_24 = regs[24]; assign gpr_25 = regs[25]; assign gpr_26 = regs[26];
  assign gpr_27 = regs[27]; assign gpr_28 = regs[28]; assign gpr_29 = regs[29];
  assign gpr_30 = regs[30]; assign gpr_31 = regs[31];

  // Read ports go through the named view so every gpr_N has a real load.
  assign view = '{gpr_0,  gpr_1,  gpr_2,  gpr_3,  gpr_4,  gpr_5,  gpr_6,  gpr_7,
                  gpr_8,  gpr_9,  gpr_10, gpr_11, gpr_12, gpr_13, gpr_14, gpr_15,
                  gpr_16, gpr_17, gpr_18, gpr_19, gpr_20, gpr_21, gpr_22, gpr_23,
                  gpr_24, gpr_25, gpr_26, gpr_27, gpr_28, gpr_29, gpr_30, gpr_31};

  assign rs1_data = view[rs1_addr];
  assign rs2_data = view[rs2_addr];

endmodule

// File: rtl/rv32_cpu.sv
// Single-cycle RV32I core: decodes and executes io_inst every clock, with
// external instruction fetch and a shared load/store address bus.
module rv32_cpu
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] io_inst,
  input  logic [XLEN-1:0] io_mem_rdata,
  output logic [2:0]      io_mem_wop,
  output logic [XLEN-1:0] io_mem_wdata,
  output logic            io_mem_wen,
  output logic [XLEN-1:0] io_mem_raddr,
  output logic [XLEN-1:0] io_pc
);

  logic [XLEN-1:0] pc, pc_plus4, next_pc;
  logic [6:0]      opcode;
  logic [RIDX-1:0] rd, rs1, rs2;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [XLEN-1:0] alu_a, alu_b, alu_res, wb_val, agen;
  alu_op_e         alu_op;
  wb_sel_e         wb_sel;
  logic            rd_we, is_load, is_store, br_taken;

  assign opcode = io_inst[6:0];
  assign rd     = io_inst[11:7];
  assign funct3 = io_inst[14:12];
  assign rs1    = io_inst[19:15];
  assign rs2    = io_inst[24:20];

  assign imm_i = {{20{io_inst[31]}}, io_inst[31:20]};
  assign imm_s = {{20{io_inst[31]}}, io_inst[31:25], io_inst[11:7]};
  assign imm_b = {{19{io_inst[31]}}, io_inst[31], io_inst[7], io_inst[30:25],
                  io_inst[11:8], 1'b0};
  assign imm_u = {io_inst[31:12], 12'b0};
  assign imm_j = {{11{io_inst[31]}}, io_inst[31], io_inst[19:12], io_inst[20],
                  io_inst[30:21], 1'b0};

  assign pc_plus4 = pc + XLEN'(4);

  rv32_regfile REG (
    .clock    (clock),
    .reset    (reset),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rs1_data (rs1_val),
    .rs2_data (rs2_val),
    .wen      (rd_we),
    .rd_addr  (rd),
    .rd_data  (wb_val)
  );

  // Branch condition; reserved funct3 values never take.
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      F3_BEQ:  br_taken = (rs1_val == rs2_val);
      F3_BNE:  br_taken = (rs1_val != rs2_val);
      F3_BLT:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
      F3_BGE:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      F3_BLTU: br_taken = (rs1_val <  rs2_val);
      F3_BGEU: br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  // Main decode; anything unrecognised falls through as a NOP.
  always_comb begin
    alu_op   = ALU_ADD;
    alu_a    = rs1_val;
    alu_b    = imm_i;
    wb_sel   = WB_ALU;
    rd_we    = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
    next_pc  = pc_plus4;
    case (opcode)
      OPC_LUI: begin
        alu_a = '0;
        alu_b = imm_u;
        rd_we = 1'b1;
      end
      OPC_AUIPC: begin
        alu_a = pc;
        alu_b = imm_u;
        rd_we = 1'b1;
      end
      OPC_JAL: begin
        wb_sel  = WB_PC4;
        rd_we   = 1'b1;
        next_pc = pc + imm_j;
      end
      OPC_JALR: begin
        wb_sel  = WB_PC4;
        rd_we   = 1'b1;
        next_pc = {alu_res[XLEN-1:1], 1'b0};
      end
      OPC_BRANCH: begin
        if (br_taken) next_pc = pc + imm_b;
      end
      OPC_LOAD: begin
        if (is_load_f3(funct3)) begin
          is_load = 1'b1;
          wb_sel  = WB_MEM;
          rd_we   = 1'b1;
        end
      end
      OPC_STORE: begin
        is_store = is_store_f3(funct3);
      end
      OPC_OPIMM: begin
        alu_op = alu_from_f3(funct3, io_inst[30], 1'b0);
        rd_we  = 1'b1;
      end
      OPC_OP: begin
        alu_op = alu_from_f3(funct3, io_inst[30], 1'b1);
        alu_b  = rs2_val;
        rd_we  = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU; shift amounts use only the low five bits of operand b.
  always_comb begin
    alu_res = alu_a + alu_b;
    case (alu_op)
      ALU_ADD:  alu_res = alu_a + alu_b;
      ALU_SUB:  alu_res = alu_a - alu_b;
      ALU_SLL:  alu_res = alu_a << alu_b[4:0];
      ALU_SLT:  alu_res = XLEN'($signed(alu_a) < $signed(alu_b));
      ALU_SLTU: alu_res = XLEN'(alu_a < alu_b);
      ALU_XOR:  alu_res = alu_a ^ alu_b;
      ALU_SRL:  alu_res = alu_a >> alu_b[4:0];
      ALU_SRA:  alu_res = XLEN'($signed(alu_a) >>> alu_b[4:0]);
      ALU_OR:   alu_res = alu_a | alu_b;
      ALU_AND:  alu_res = alu_a & alu_b;
      default:  alu_res = alu_a + alu_b;
    endcase
  end

  always_comb begin
    wb_val = alu_res;
    case (wb_sel)
      WB_PC4:  wb_val = pc_plus4;
      WB_MEM:  wb_val = io_mem_rdata;
      default: wb_val = alu_res;
    endcase
  end

  assign agen         = rs1_val + (is_store ? imm_s : imm_i);
  assign io_mem_raddr = (is_load || is_store) ? agen : '0;
  assign io_mem_wop   = (is_load || is_store) ? funct3 : 3'b000;
  assign io_mem_wdata = rs2_val;
  assign io_mem_wen   = is_store && reset;
  assign io_pc        = pc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) pc <= RESET_PC;
    else        pc <= next_pc;
  end

endmodule

// File: tb/tb_rv32_cpu.sv
// Bench for rv32_cpu: directed ISA scenarios plus random instruction streams,
// checked every cycle against an instruction-level model of RV32I.
module tb_rv32_cpu;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] io_inst, io_mem_rdata;
  logic [2:0]  io_mem_wop;
  logic [31:0] io_mem_wdata, io_mem_raddr, io_pc;
  logic        io_mem_wen;

  rv32_cpu dut (
    .clock        (clock),
    .reset        (reset),
    .io_inst      (io_inst),
    .io_mem_rdata (io_mem_rdata),
    .io_mem_wop   (io_mem_wop),
    .io_mem_wdata (io_mem_wdata),
    .io_mem_wen   (io_mem_wen),
    .io_mem_raddr (io_mem_raddr),
    .io_pc        (io_pc)
  );

  always #5 clock = ~clock;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JALR = 7'h67, LOAD = 7'h03;
  localparam logic [6:0] OPI = 7'h13, OPR = 7'h33;

  int checks = 0;
  int errors = 0;

  // Architectural model state and the expectations for the current instruction.
  logic [31:0] m_pc;
  logic [31:0] m_x [32];
  logic        e_wen, e_st, e_we;
  logic [2:0]  e_wop;
  logic [4:0]  e_rd;
  logic [31:0] e_addr, e_wdata, e_npc, e_val;
  logic        s_wen;
  logic [2:0]  s_wop;
  logic [31:0] s_addr, s_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (pc model %08h)", name, act, exp, m_pc);
    end
  endtask

  function automatic logic [31:0] dut_gpr(input int i);
    case (i)
      0:  return dut.REG.gpr_0;   1: return dut.REG.gpr_1;   2: return dut.REG.gpr_2;
      3:  return dut.REG.gpr_3;   4: return dut.REG.gpr_4;   5: return dut.REG.gpr_5;
      6:  return dut.REG.gpr_6;   7: return dut.REG.gpr_7;   8: return dut.REG.gpr_8;
      9:  return dut.REG.gpr_9;  10: return dut.REG.gpr_10; 11: return dut.REG.gpr_11;
      12: return dut.REG.gpr_12; 13: return dut.REG.gpr_13; 14: return dut.REG.gpr_14;
      15: return dut.REG.gpr_15; 16: return dut.REG.gpr_16; 17: return dut.REG.gpr_17;
      18: return dut.REG.gpr_18; 19: return dut.REG.gpr_19; 20: return dut.REG.gpr_20;
      21: return dut.REG.gpr_21; 22: return dut.REG.gpr_22; 23: return dut.REG.gpr_23;
      24: return dut.REG.gpr_24; 25: return dut.REG.gpr_25; 26: return dut.REG.gpr_26;
      27: return dut.REG.gpr_27; 28: return dut.REG.gpr_28; 29: return dut.REG.gpr_29;
      30: return dut.REG.gpr_30; 31: return dut.REG.gpr_31;
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
      input logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic sub_or_sra,
      input logic [31:0] a, input logic [31:0] b, input logic reg_form);
    int unsigned sh = int'(b[4:0]);
    case (f3)
      3'd0: return (reg_form && sub_or_sra) ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return sub_or_sra ? 32'($signed(a) >>> sh) : a >> sh;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // ISA-level behaviour of one instruction from the current model state.
  task automatic model_eval(input logic [31:0] ins, input logic [31:0] rdata);
    logic [31:0] a, b, ii, is_, ib, ij;
    logic [2:0]  f3;
    logic        taken;
    a   = m_x[ins[19:15]];
    b   = m_x[ins[24:20]];
    f3  = ins[14:12];
    ii  = 32'($signed(ins[31:20]));
    is_ = 32'($signed({ins[31:25], ins[11:7]}));
    ib  = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    ij  = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    e_wen = 0; e_st = 0; e_we = 0; e_wop = 0; e_addr = 0; e_wdata = 0;
    e_rd = ins[11:7]; e_val = 0; e_npc = m_pc + 32'd4;
    case (ins[6:0])
      7'h37: begin e_we = 1; e_val = {ins[31:12], 12'h000}; end
      7'h17: begin e_we = 1; e_val = m_pc + {ins[31:12], 12'h000}; end
      7'h6f: begin e_we = 1; e_val = m_pc + 32'd4; e_npc = m_pc + ij; end
      7'h67: begin e_we = 1; e_val = m_pc + 32'd4; e_npc = (a + ii) & 32'hFFFF_FFFE; end
      7'h63: begin
        case (f3)
          3'd0: taken = (a == b);
          3'd1: taken = (a != b);
          3'd4: taken = ($signed(a) < $signed(b));
          3'd5: taken = ($signed(a) >= $signed(b));
          3'd6: taken = (a < b);
          3'd7: taken = (a >= b);
          default: taken = 0;
        endcase
        if (taken) e_npc = m_pc + ib;
      end
      7'h03: if (f3 != 3'd3 && f3 < 3'd6) begin
        e_we = 1; e_val = rdata; e_wop = f3; e_addr = a + ii;
      end
      7'h23: if (f3 < 3'd3) begin
        e_wen = 1; e_st = 1; e_wop = f3; e_addr = a + is_; e_wdata = b;
      end
      7'h13: begin e_we = 1; e_val = ref_alu(f3, ins[30], a, ii, 1'b0); end
      7'h33: begin e_we = 1; e_val = ref_alu(f3, ins[30], a, b, 1'b1); end
      default: ;
    endcase
  endtask

  task automatic model_reset();
    m_pc = 32'h8000_0000;
    for (int i = 0; i < 32; i++) m_x[i] = '0;
  endtask

  task automatic check_regs();
    for (int i = 0; i < 32; i++) chk($sformatf("x%0d", i), dut_gpr(i), m_x[i]);
  endtask

  // One instruction: outputs checked mid-cycle, state checked after the edge.
  task automatic step(input logic [31:0] ins, input logic [31:0] rdata = 32'h0);
    @(negedge clock);
    io_inst = ins;
    io_mem_rdata = rdata;
    #1;
    model_eval(ins, rdata);
    s_wen = io_mem_wen; s_wop = io_mem_wop; s_addr = io_mem_raddr; s_wdata = io_mem_wdata;
    chk("pc", io_pc, m_pc);
    chk("wen", 32'(io_mem_wen), 32'(e_wen));
    chk("wop", 32'(io_mem_wop), 32'(e_wop));
    chk("addr", io_mem_raddr, e_addr);
    if (e_st) chk("wdata", io_mem_wdata, e_wdata);
    @(posedge clock);
    #1;
    if (e_we && e_rd != 5'd0) m_x[e_rd] = e_val;
    m_pc = e_npc;
    chk("pc_next", io_pc, m_pc);
    check_regs();
  endtask

  task automatic do_reset();
    @(negedge clock);
    io_inst = enc_s(12'd4, 5'd6, 5'd5, 3'd2);
    #1 reset = 1'b0;
    model_reset();
    #2 chk("rst_wen", 32'(io_mem_wen), 32'h0);
    repeat (2) @(posedge clock);
    #1 chk("rst_pc", io_pc, 32'h8000_0000);
    for (int i = 0; i < 32; i++) chk($sformatf("rst_x%0d", i), dut_gpr(i), 32'h0);
    io_inst = NOP;
    reset = 1'b1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [4:0]  rd  = 5'($urandom_range(0, 15));
    logic [4:0]  rs1 = 5'($urandom_range(0, 7));
    logic [4:0]  rs2 = 5'($urandom_range(0, 7));
    logic [2:0]  f3  = 3'($urandom);
    logic [11:0] imm = 12'($urandom);
    logic [6:0]  f7;
    case ($urandom_range(0, 12))
      0:  return enc_u(20'($urandom), rd, LUI);
      1:  return enc_u(20'($urandom), rd, AUIPC);
      2:  return enc_j(21'($urandom), rd);
      3:  return enc_i(imm, rs1, 3'd0, rd, JALR);
      4:  return enc_b(13'($urandom), rs2, rs1, f3);
      5:  return enc_i(imm, rs1, ($urandom_range(0, 1) != 0) ? 3'($urandom_range(0, 2))
                                                           : 3'($urandom_range(4, 5)), rd, LOAD);
      6:  return enc_s(imm, rs2, rs1, 3'($urandom_range(0, 2)));
      7, 8: begin
        if (f3 == 3'd1) imm[11:5] = 7'd0;
        if (f3 == 3'd5) imm[11:5] = {1'b0, imm[10], 5'd0};
        return enc_i(imm, rs1, f3, rd, OPI);
      end
      9, 10, 11: begin
        f7 = (f3 == 3'd0 || f3 == 3'd5) ? {1'b0, 1'($urandom), 5'd0} : 7'd0;
        return enc_r(f7, rs2, rs1, f3, rd, OPR);
      end
      default: begin
        case ($urandom_range(0, 3))
          0: return 32'h0010_0073;
          1: return 32'h0000_0073;
          2: return 32'h0000_000F;
          default: return {25'($urandom), 7'h7F};
        endcase
      end
    endcase
  endfunction

  initial begin
    io_inst = NOP;
    io_mem_rdata = '0;
    reset = 1'b1;
    model_reset();
    do_reset();

    // Arithmetic and PC progression.
    step(32'h0050_0513);
    chk("addi_x10", dut_gpr(10), 32'd5);
    chk("addi_pc", io_pc, 32'h8000_0004);
    step(enc_r(7'd0, 5'd10, 5'd10, 3'd0, 5'd11, OPR));
    chk("add_x11", dut_gpr(11), 32'd10);
    chk("add_pc", io_pc, 32'h8000_0008);

    // Store then sign-extended load through the shared bus.
    step(enc_u(20'h80001, 5'd5, LUI));
    step(enc_u(20'h12345, 5'd6, LUI));
    step(enc_i(12'h678, 5'd6, 3'd0, 5'd6, OPI));
    step(enc_s(12'd4, 5'd6, 5'd5, 3'd2));
    chk("sw_wen", 32'(s_wen), 32'h1);
    chk("sw_addr", s_addr, 32'h8000_1004);
    chk("sw_wdata", s_wdata, 32'h1234_5678);
    chk("sw_wop", 32'(s_wop), 32'h2);
    step(enc_i(12'd0, 5'd5, 3'd0, 5'd7, LOAD), 32'hFFFF_FF80);
    chk("lb_x7", dut_gpr(7), 32'hFFFF_FF80);
    chk("lb_wop", 32'(s_wop), 32'h0);
    chk("lb_wen", 32'(s_wen), 32'h0);

    // Control flow from a fresh reset.
    do_reset();
    step(enc_b(13'd8, 5'd0, 5'd0, 3'd0));
    chk("beq_pc", io_pc, 32'h8000_0008);
    step(NOP);
    step(NOP);
    step(enc_j(21'(-8), 5'd1));
    chk("jal_pc", io_pc, 32'h8000_0008);
    chk("jal_x1", dut_gpr(1), 32'h8000_0014);
    step(enc_i(12'd1, 5'd1, 3'd0, 5'd0, JALR));
    chk("jalr_pc", io_pc, 32'h8000_0014);
    step(enc_i(12'd7, 5'd0, 3'd0, 5'd0, OPI));
    chk("x0_zero", dut_gpr(0), 32'h0);
    step(32'h0010_0073);
    chk("ebreak_pc", io_pc, 32'h8000_001C);
    chk("ebreak_a0", dut_gpr(10), 32'h0);

    // Random instruction stream.
    for (int n = 0; n < 3000; n++) step(rand_inst(), $urandom);

    // Reset arriving mid-cycle must abort the pending write and PC update.
    step(enc_i(12'h0AA, 5'd0, 3'd0, 5'd12, OPI));
    @(negedge clock);
    io_inst = enc_i(12'h123, 5'd0, 3'd0, 5'd12, OPI);
    #2 reset = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
    chk("abort_pc", io_pc, 32'h8000_0000);
    chk("abort_x12", dut_gpr(12), 32'h0);
    io_inst = NOP;
    reset = 1'b1;
    for (int n = 0; n < 200; n++) step(rand_inst(), $urandom);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
